// File: rtl/fifo_bw_bounded.sv
// M-write / N-read TID-routed FIFO with bounded per-thread circular queues.
// Backpressure is derived from occupancy only, so M pushes never overflow.
module fifo_bw_bounded #(
  parameter int M          = 2,
  parameter int N          = 3,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int TID_WIDTH  = 4
) (
  input  logic                       clk,
  input  logic                       arst_n,
  output logic                       full_n  [0:M-1],
  input  logic                       write   [0:M-1],
  input  logic [DATA_WIDTH-1:0]      din     [0:M-1],
  output logic                       empty_n [0:N-1],
  input  logic                       read    [0:N-1],
  output logic [DATA_WIDTH-1:0]      dout    [0:N-1],
  output logic [$clog2(DEPTH+1)-1:0] count   [0:N-1],
  output logic                       tid_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] THR = CW'(DEPTH - M);
  localparam logic [TID_WIDTH:0] NQ = (TID_WIDTH + 1)'(N);

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < M) ||
      (N > (2 ** TID_WIDTH))) begin : g_bad_params
    $fatal(1, "fifo_bw_bounded: illegal DEPTH/M/N/TID_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [N][DEPTH];

  logic [PW-1:0] wr_ptr_q [N];
  logic [PW-1:0] wr_ptr_d [N];
  logic [PW-1:0] rd_ptr_q [N];
  logic [PW-1:0] rd_ptr_d [N];
  logic [CW-1:0] cnt_q    [N];
  logic [CW-1:0] cnt_d    [N];
  logic [CW-1:0] push_cnt [N];
  logic          pop      [N];

  logic                 acc   [M];
  logic [PW-1:0]        waddr [M];
  logic [TID_WIDTH-1:0] tid   [M];

  logic space;
  logic bad_tid;
  logic tid_err_q;
  logic tid_err_d;

  always_comb begin
    space = 1'b1;
    for (int j = 0; j < N; j++) begin
      if (cnt_q[j] > THR) space = 1'b0;
    end
    for (int i = 0; i < M; i++) begin
      full_n[i] = space;
    end
  end

  // Writers are walked in index order so lower indices land first.
  always_comb begin
    bad_tid = 1'b0;
    for (int j = 0; j < N; j++) begin
      push_cnt[j] = '0;
    end
    for (int i = 0; i < M; i++) begin
      tid[i]   = din[i][TID_WIDTH-1:0];
      acc[i]   = space & write[i] & ({1'b0, tid[i]} < NQ);
      waddr[i] = '0;
      if (write[i] && ({1'b0, tid[i]} >= NQ)) bad_tid = 1'b1;
      for (int j = 0; j < N; j++) begin
        if (acc[i] && (tid[i] == TID_WIDTH'(j))) begin
          waddr[i]    = wr_ptr_q[j] + PW'(push_cnt[j]);
          push_cnt[j] = push_cnt[j] + CW'(1);
        end
      end
    end
    for (int j = 0; j < N; j++) begin
      pop[j]      = (cnt_q[j] != '0) & read[j];
      cnt_d[j]    = cnt_q[j] + push_cnt[j] - CW'(pop[j]);
      wr_ptr_d[j] = wr_ptr_q[j] + PW'(push_cnt[j]);
      rd_ptr_d[j] = rd_ptr_q[j] + PW'(pop[j]);
    end
    tid_err_d = tid_err_q | bad_tid;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        if (acc[i] && (tid[i] == TID_WIDTH'(j))) begin
          mem_q[j][waddr[i]] <= din[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int j = 0; j < N; j++) begin
        wr_ptr_q[j] <= '0;
        rd_ptr_q[j] <= '0;
        cnt_q[j]    <= '0;
      end
      tid_err_q <= 1'b0;
    end else begin
      for (int j = 0; j < N; j++) begin
        wr_ptr_q[j] <= wr_ptr_d[j];
        rd_ptr_q[j] <= rd_ptr_d[j];
        cnt_q[j]    <= cnt_d[j];
      end
      tid_err_q <= tid_err_d;
    end
  end

  always_comb begin
    for (int j = 0; j < N; j++) begin
      count[j]   = cnt_q[j];
      empty_n[j] = (cnt_q[j] != '0);
      dout[j]    = (cnt_q[j] != '0) ? mem_q[j][rd_ptr_q[j]] : '0;
    end
  end

  assign tid_err = tid_err_q;

endmodule

// File: tb/tb_fifo_bw_bounded.sv
// Bench for fifo_bw_bounded: directed scenarios plus random traffic
// checked against a queue-based model of the routing rules.
module tb_fifo_bw_bounded;

  localparam int M     = 2;
  localparam int N     = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int TW    = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          arst_n;
  logic          full_n  [0:M-1];
  logic          write   [0:M-1];
  logic [DW-1:0] din     [0:M-1];
  logic          empty_n [0:N-1];
  logic          read    [0:N-1];
  logic [DW-1:0] dout    [0:N-1];
  logic [CW-1:0] count   [0:N-1];
  logic          tid_err;

  fifo_bw_bounded #(
    .M(M), .N(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TID_WIDTH(TW)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .full_n(full_n), .write(write), .din(din),
    .empty_n(empty_n), .read(read), .dout(dout),
    .count(count), .tid_err(tid_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] mq [N][$];
  bit  merr;
  int  acc_n [M];
  int  pop_n [N];
  int  peak  [N];
  int  cycles;

  task automatic idle();
    for (int i = 0; i < M; i++) begin
      write[i] = 1'b0;
      din[i]   = '0;
    end
    for (int j = 0; j < N; j++) read[j] = 1'b0;
  endtask

  function automatic logic [DW-1:0] mkword(int t);
    return {28'($urandom()), 4'(t)};
  endfunction

  // Model step from current inputs, then advance one clock.
  task automatic tick();
    bit sp;
    int t;
    sp = 1;
    for (int j = 0; j < N; j++)
      if (mq[j].size() > DEPTH - M) sp = 0;
    for (int j = 0; j < N; j++) begin
      if (read[j] && mq[j].size() != 0) begin
        void'(mq[j].pop_front());
        pop_n[j]++;
      end
    end
    for (int i = 0; i < M; i++) begin
      if (write[i]) begin
        t = int'(din[i][TW-1:0]);
        if (t >= N) merr = 1;
        else if (sp) begin
          mq[t].push_back(din[i]);
          acc_n[i]++;
        end
      end
    end
    for (int j = 0; j < N; j++)
      if (mq[j].size() > peak[j]) peak[j] = mq[j].size();
    cycles++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < M; i++) begin
      n_chk++;
      if (full_n[i] !== 1'b1)
        $display("FAIL reset_full_n[%0d]: got %b want 1", i, full_n[i]);
      else n_pass++;
    end
    for (int j = 0; j < N; j++) begin
      n_chk++;
      if (empty_n[j] !== 1'b0 || count[j] !== '0 || dout[j] !== '0)
        $display("FAIL reset_q[%0d]: got e=%b c=%0d d=%h want 0/0/0",
                 j, empty_n[j], count[j], dout[j]);
      else n_pass++;
    end
    n_chk++;
    if (tid_err !== 1'b0)
      $display("FAIL reset_tid_err: got %b want 0", tid_err);
    else n_pass++;
  endtask

  task automatic test_pair_order();
    write[0] = 1'b1; din[0] = 32'h10;
    write[1] = 1'b1; din[1] = 32'h20;
    tick(); idle();
    n_chk++;
    if (dout[0] !== 32'h10 || count[0] !== 4'd2 || empty_n[0] !== 1'b1)
      $display("FAIL pair_first: got d=%h c=%0d e=%b want 10/2/1",
               dout[0], count[0], empty_n[0]);
    else n_pass++;
    read[0] = 1'b1;
    tick(); idle();
    n_chk++;
    if (dout[0] !== 32'h20 || count[0] !== 4'd1)
      $display("FAIL pair_second: got d=%h c=%0d want 20/1",
               dout[0], count[0]);
    else n_pass++;
    read[0] = 1'b1;
    tick();
    tick(); idle();
    n_chk++;
    if (count[0] !== 4'd0 || empty_n[0] !== 1'b0 || dout[0] !== '0)
      $display("FAIL pair_drain: got c=%0d e=%b d=%h want 0/0/0",
               count[0], empty_n[0], dout[0]);
    else n_pass++;
  endtask

  task automatic test_full();
    for (int c = 0; c < 3; c++) begin
      write[0] = 1'b1; din[0] = mkword(1);
      write[1] = 1'b1; din[1] = mkword(1);
      tick();
    end
    idle();
    n_chk++;
    if (count[1] !== 4'd6 || full_n[0] !== 1'b1)
      $display("FAIL full_six: got c=%0d f=%b want 6/1",
               count[1], full_n[0]);
    else n_pass++;
    write[0] = 1'b1; din[0] = mkword(1);
    tick(); idle();
    n_chk++;
    if (count[1] !== 4'd7 || full_n[0] !== 1'b0 || full_n[1] !== 1'b0)
      $display("FAIL full_seven: got c=%0d f=%b%b want 7/00",
               count[1], full_n[0], full_n[1]);
    else n_pass++;
    write[0] = 1'b1; din[0] = mkword(1);
    write[1] = 1'b1; din[1] = mkword(1);
    tick(); idle();
    n_chk++;
    if (count[1] !== 4'd7)
      $display("FAIL full_blocked: got c=%0d want 7", count[1]);
    else n_pass++;
    read[1] = 1'b1;
    tick(); idle();
    n_chk++;
    if (count[1] !== 4'd6 || full_n[0] !== 1'b1 || full_n[1] !== 1'b1)
      $display("FAIL full_release: got c=%0d f=%b%b want 6/11",
               count[1], full_n[0], full_n[1]);
    else n_pass++;
    for (int c = 0; c < 6; c++) begin
      n_chk++;
      if (dout[1] !== mq[1][0])
        $display("FAIL full_drain_data: got %h want %h", dout[1], mq[1][0]);
      else n_pass++;
      read[1] = 1'b1;
      tick(); idle();
    end
    n_chk++;
    if (count[1] !== 4'd0 || empty_n[1] !== 1'b0)
      $display("FAIL full_drain_end: got c=%0d e=%b want 0/0",
               count[1], empty_n[1]);
    else n_pass++;
  endtask

  task automatic test_steady();
    for (int c = 0; c < 2; c++) begin
      write[0] = 1'b1; din[0] = mkword(2);
      write[1] = 1'b1; din[1] = mkword(2);
      tick();
    end
    idle();
    for (int c = 0; c < 20; c++) begin
      write[0] = 1'b1; din[0] = mkword(2);
      read[2]  = 1'b1;
      tick(); idle();
      n_chk++;
      if (count[2] !== 4'd4 || dout[2] !== mq[2][0])
        $display("FAIL steady[%0d]: got c=%0d d=%h want 4/%h",
                 c, count[2], dout[2], mq[2][0]);
      else n_pass++;
    end
    for (int c = 0; c < 4; c++) begin
      read[2] = 1'b1;
      tick(); idle();
    end
    n_chk++;
    if (count[2] !== 4'd0)
      $display("FAIL steady_drain: got c=%0d want 0", count[2]);
    else n_pass++;
  endtask

  task automatic test_tid_err();
    write[0] = 1'b1; din[0] = 32'h5;
    tick(); idle();
    n_chk++;
    if (tid_err !== 1'b1 || count[0] !== '0 || count[1] !== '0 ||
        count[2] !== '0)
      $display("FAIL tid_err_set: got e=%b c=%0d,%0d,%0d want 1/0,0,0",
               tid_err, count[0], count[1], count[2]);
    else n_pass++;
    tick(); tick(); tick();
    n_chk++;
    if (tid_err !== 1'b1)
      $display("FAIL tid_err_sticky: got %b want 1", tid_err);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_d;
    bit            sp;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < M; i++) begin
        write[i] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0)
          din[i] = mkword($urandom_range(N, 15));
        else
          din[i] = mkword($urandom_range(0, N - 1));
      end
      for (int j = 0; j < N; j++) read[j] = ($urandom_range(0, 2) == 0);
      tick(); idle();
      sp = 1;
      for (int j = 0; j < N; j++) begin
        if (mq[j].size() > DEPTH - M) sp = 0;
        exp_d = (mq[j].size() != 0) ? mq[j][0] : '0;
        n_chk++;
        if (count[j] !== CW'(mq[j].size()) || dout[j] !== exp_d ||
            empty_n[j] !== (mq[j].size() != 0))
          $display("FAIL rnd_q[%0d] cyc %0d: got c=%0d d=%h want c=%0d d=%h",
                   j, c, count[j], dout[j], mq[j].size(), exp_d);
        else n_pass++;
      end
      for (int i = 0; i < M; i++) begin
        n_chk++;
        if (full_n[i] !== sp)
          $display("FAIL rnd_full_n[%0d] cyc %0d: got %b want %b",
                   i, c, full_n[i], sp);
        else n_pass++;
      end
      n_chk++;
      if (tid_err !== merr)
        $display("FAIL rnd_tid_err cyc %0d: got %b want %b", c, tid_err, merr);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    write[0] = 1'b1; din[0] = mkword(0);
    write[1] = 1'b1; din[1] = mkword(1);
    tick(); tick(); idle();
    #2;
    arst_n = 1'b0;
    #1;
    for (int j = 0; j < N; j++) begin
      mq[j].delete();
      n_chk++;
      if (empty_n[j] !== 1'b0 || count[j] !== '0 || dout[j] !== '0)
        $display("FAIL midrst_q[%0d]: got e=%b c=%0d d=%h want 0/0/0",
                 j, empty_n[j], count[j], dout[j]);
      else n_pass++;
    end
    merr = 0;
    n_chk++;
    if (tid_err !== 1'b0 || full_n[0] !== 1'b1)
      $display("FAIL midrst_flags: got e=%b f=%b want 0/1",
               tid_err, full_n[0]);
    else n_pass++;
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    write[0] = 1'b1; din[0] = 32'h0000_0AB2;
    tick(); idle();
    n_chk++;
    if (dout[2] !== 32'h0000_0AB2 || count[2] !== 4'd1 ||
        count[0] !== '0 || count[1] !== '0)
      $display("FAIL midrst_after: got d=%h c=%0d,%0d,%0d want AB2/0,0,1",
               dout[2], count[0], count[1], count[2]);
    else n_pass++;
  endtask

  initial begin
    arst_n = 1'b0;
    merr   = 0;
    cycles = 0;
    for (int i = 0; i < M; i++) acc_n[i] = 0;
    for (int j = 0; j < N; j++) begin
      pop_n[j] = 0;
      peak[j]  = 0;
    end
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_pair_order();
    test_full();
    test_steady();
    test_tid_err();
    test_random();
    test_reset_mid();
    $display("stats: cycles %0d acc w0 %0d w1 %0d pops %0d %0d %0d peak %0d %0d %0d",
             cycles, acc_n[0], acc_n[1], pop_n[0], pop_n[1], pop_n[2],
             peak[0], peak[1], peak[2]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
